flow_sequencer: RTL

- Instruction sequencer for the microfluidic controller.
- Fetches 16-bit program words from the program ROM, addressed by the 8-bit program counter block `pc`.
- Decodes each word into a valve-set, delay, NOP or HALT operation.
- Drives the `pc` handshake strobes (set, delay, set_done, count_done) so the program counter advances exactly once per completed instruction.
- Contains the delay tick counter and the valve-driver handshake, including an ack timeout.

---
 rtl/flow_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/flow_sequencer.sv
// flow_sequencer: fetch/decode sequencer driving valve writes, tick delays and pc strobes.
// Define SEQ_PAUSE_EN to add a pause input that freezes FETCH and DELAY counting.
module flow_sequencer #(
    parameter int INSTR_W     = 16,
    parameter int OPERAND_W   = INSTR_W - 2,
    parameter int PRESCALE    = 100,
    parameter int ACK_TIMEOUT = 255,
    parameter int FETCH_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
`ifdef SEQ_PAUSE_EN
    input  logic                 pause,
`endif
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 valve_ack,
    output logic                 valve_we,
    output logic [OPERAND_W-1:0] valve_data,
    output logic                 set,
    output logic                 set_done,
    output logic                 delay,
    output logic                 count_done,
    output logic                 busy,
    output logic                 halted,
    output logic                 err
);
    localparam int FW = $clog2(FETCH_LAT + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [FW-1:0] F_LOAD = FW'(FETCH_LAT);
    localparam logic [TW-1:0] T_LOAD = TW'(ACK_TIMEOUT);
    localparam logic [PW-1:0] P_LOAD = PW'(PRESCALE - 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_SET = 3'd3,
                           S_DELAY = 3'd4, S_ADV = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;
    logic [2:0]           state;
    logic                 adv_set;
    logic [FW-1:0]        fcnt;
    logic [TW-1:0]        tcnt;
    logic [PW-1:0]        pre;
    logic [OPERAND_W-1:0] ticks;
    logic                 pz;
    logic [1:0]           op;
    logic [OPERAND_W-1:0] operand;
`ifdef SEQ_PAUSE_EN
    assign pz = pause;
`else
    assign pz = 1'b0;
`endif
    assign op      = instr[INSTR_W-1 -: 2];
    assign operand = instr[OPERAND_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            adv_set    <= 1'b0;
            fcnt       <= '0;
            tcnt       <= '0;
            pre        <= '0;
            ticks      <= '0;
            valve_data <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_FETCH;
                    fcnt  <= F_LOAD;
                end
                S_FETCH: if (!pz) begin
                    if (fcnt == FW'(1)) state <= S_DECODE;
                    fcnt <= fcnt - FW'(1);
                end
                S_DECODE: begin
                    adv_set <= 1'b0;
                    case (op)
                        2'b01: begin
                            state      <= S_SET;
                            valve_data <= operand;
                            tcnt       <= T_LOAD;
                        end
                        2'b10: if (operand != '0) begin
                            state <= S_DELAY;
                            ticks <= operand;
                            pre   <= P_LOAD;
                        end else state <= S_ADV;
                        2'b00: state <= S_ADV;
                        default: state <= S_HALT;
                    endcase
                end
                // ack in the expiry cycle wins over the timeout
                S_SET: if (valve_ack) begin
                    state   <= S_ADV;
                    adv_set <= 1'b1;
                end else if (tcnt == TW'(1)) state <= S_ERR;
                else tcnt <= tcnt - TW'(1);
                S_DELAY: if (!pz) begin
                    if (pre != '0) pre <= pre - PW'(1);
                    else if (ticks == OPERAND_W'(1)) state <= S_ADV;
                    else begin
                        ticks <= ticks - OPERAND_W'(1);
                        pre   <= P_LOAD;
                    end
                end
                S_ADV: begin
                    state <= S_FETCH;
                    fcnt  <= F_LOAD;
                end
                S_HALT: if (start) begin
                    state   <= S_ADV;
                    adv_set <= 1'b0;
                end
                S_ERR: if (start) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
    assign valve_we   = state == S_SET;
    assign set        = state == S_SET;
    assign delay      = state == S_DELAY;
    assign set_done   = state == S_ADV && adv_set;
    assign count_done = state == S_ADV && !adv_set;
    assign busy       = !(state == S_IDLE || state == S_HALT || state == S_ERR);
    assign halted     = state == S_HALT;
    assign err        = state == S_ERR;
endmodule
